// File: rtl/bcd_timer_ctrl_pkg.sv
// Shared state encoding and BCD constants for the bcd_timer_ctrl down-timer.
// Optional auto-reload behaviour is enabled by defining BCD_TIMER_AUTO_RELOAD_EN.
package bcd_timer_ctrl_pkg;

  localparam int NIB_W = 4;
  localparam logic [NIB_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [NIB_W-1:0] bcd_clamp(input logic [NIB_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_bcd_digit_dn.sv
// One decade (0-9) down-counting digit with clamped parallel load and borrow chaining.
module bcd_digit_dn
  import bcd_timer_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NIB_W-1:0] load_nibble,
  input  logic             dec_en,
  output logic [NIB_W-1:0] digit,
  output logic             borrow_out
);

  logic [NIB_W-1:0] digit_q;
  logic [NIB_W-1:0] digit_d;

  // Next digit value: load wins over decrement; 0 wraps to 9 and borrows upward.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_nibble);
    end else if (dec_en) begin
      digit_d = (digit_q == 4'd0) ? BCD_MAX : (digit_q - 4'd1);
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = dec_en && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Programmable multi-digit BCD down-timer: FSM, prescaler and cascaded decade digits.
// Define BCD_TIMER_AUTO_RELOAD_EN to reload the stored preset instead of stopping at zero.
module bcd_timer_ctrl
  import bcd_timer_ctrl_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    load,
  input  logic [NIB_W*DIGITS-1:0] load_val,
  output logic [NIB_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    done,
  output logic                    tick
);

  localparam int CW = NIB_W * DIGITS;
  localparam int PW = 16;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = CW'(0);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] reload_q, reload_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          tick_q, tick_d;

  logic [CW-1:0]   count_s;
  logic [CW-1:0]   load_clamped_s;
  logic [CW-1:0]   load_src_s;
  logic [DIGITS:0] borrow_s;
  logic            run_adv_s;
  logic            wrap_s;
  logic            last_dec_s;
  logic            reload_now_s;
  logic            dig_load_s;

  // Only an uninterrupted RUN cycle advances the prescaler; load/stop freeze it.
  assign run_adv_s  = (state_q == RUN) && !load && !stop;
  assign wrap_s     = run_adv_s && (presc_q == PRESC_LAST);
  assign last_dec_s = wrap_s && (count_s == COUNT_ONE);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  assign reload_now_s = last_dec_s && (reload_q != COUNT_ZERO);
`else
  assign reload_now_s = 1'b0;
`endif

  assign dig_load_s  = load || reload_now_s;
  assign load_src_s  = load ? load_val : reload_q;
  assign borrow_s[0] = wrap_s && !reload_now_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign load_clamped_s[g*NIB_W +: NIB_W] = bcd_clamp(load_val[g*NIB_W +: NIB_W]);

    bcd_digit_dn u_digit (
      .clk         (clk),
      .rst         (rst),
      .load        (dig_load_s),
      .load_nibble (load_src_s[g*NIB_W +: NIB_W]),
      .dec_en      (borrow_s[g]),
      .digit       (count_s[g*NIB_W +: NIB_W]),
      .borrow_out  (borrow_s[g+1])
    );
  end

  // State, prescaler, reload preset and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= 16'd0;
      reload_q  <= COUNT_ZERO;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
    end
  end

  // Next state: load > stop > start; a top-digit borrow can only mean underflow, so park in DONE.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    if (load) begin
      state_d  = IDLE;
      presc_d  = 16'd0;
      reload_d = load_clamped_s;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (stop) begin
            state_d = state_q;
          end else if (start) begin
            state_d = (count_s != COUNT_ZERO) ? RUN : DONE;
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (wrap_s) begin
            presc_d = 16'd0;
            if ((last_dec_s && !reload_now_s) || borrow_s[DIGITS]) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs are registered so they line up with the new count value.
  always_comb begin
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE) || reload_now_s;
    tick_d    = wrap_s;
  end

  assign count   = count_s;
  assign running = running_q;
  assign done    = done_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: decimal reference model, directed and random stimulus.
module tb_bcd_timer_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct packed {
    int mode;
    int cnt;
    int presc;
    int reload;
    bit tick;
    bit pulse;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, a_stop = 1'b0, a_load = 1'b0;
  logic [7:0]  a_lv = 8'h00;
  logic [7:0]  a_count;
  logic        a_running, a_done, a_tick;
  logic        b_start = 1'b0, b_stop = 1'b0, b_load = 1'b0;
  logic [11:0] b_lv = 12'h000;
  logic [11:0] b_count;
  logic        b_running, b_done, b_tick;

  int total = 0;
  int bad   = 0;
  int ticks;
  mdl_t ma, mb;

  bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .load(a_load), .load_val(a_lv),
    .count(a_count), .running(a_running), .done(a_done), .tick(a_tick)
  );

  bcd_timer_ctrl #(.DIGITS(3), .PRESCALE(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .load(b_load), .load_val(b_lv),
    .count(b_count), .running(b_running), .done(b_done), .tick(b_tick)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] v, input int d);
    int r, w, n;
    r = 0;
    w = 1;
    for (int i = 0; i < d; i++) begin
      n = int'(v[4*i +: 4]);
      if (n > 9) n = 9;
      r += n * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic int int2bcd(input int v);
    int x, r;
    x = v;
    r = 0;
    for (int i = 0; i < 3; i++) begin
      r += (x % 10) << (4 * i);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.mode = M_IDLE; m.cnt = 0; m.presc = 0; m.reload = 0; m.tick = 1'b0; m.pulse = 1'b0;
    return m;
  endfunction

  // Count kept as a plain decimal integer; one call = one clock edge.
  function automatic mdl_t mdl_step(input mdl_t m, input int p, input logic ld, input int ldv,
                                    input logic sp, input logic st);
    mdl_t n;
    n = m;
    n.tick = 1'b0;
    n.pulse = 1'b0;
    if (ld) begin
      n.cnt = ldv; n.reload = ldv; n.mode = M_IDLE; n.presc = 0;
    end else if (m.mode == M_RUN) begin
      if (sp) begin
        n.mode = M_PAUSE;
      end else if (m.presc == p - 1) begin
        n.presc = 0;
        n.tick = 1'b1;
        if (m.cnt == 1) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
          if (m.reload != 0) begin
            n.cnt = m.reload; n.pulse = 1'b1;
          end else begin
            n.cnt = 0; n.mode = M_DONE;
          end
`else
          n.cnt = 0; n.mode = M_DONE;
`endif
        end else begin
          n.cnt = m.cnt - 1;
        end
      end else begin
        n.presc = m.presc + 1;
      end
    end else if ((m.mode == M_IDLE || m.mode == M_PAUSE) && st && !sp) begin
      n.mode = (m.cnt != 0) ? M_RUN : M_DONE;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= mdl_rst();
      mb <= mdl_rst();
    end else begin
      ma <= mdl_step(ma, 1, a_load, bcd2int({4'h0, a_lv}, 2), a_stop, a_start);
      mb <= mdl_step(mb, 4, b_load, bcd2int(b_lv, 3), b_stop, b_start);
    end
  end

  always @(negedge clk) begin
    chk("a_count",   int'(a_count),   int2bcd(ma.cnt));
    chk("a_running", int'(a_running), int'(ma.mode == M_RUN));
    chk("a_done",    int'(a_done),    int'(ma.mode == M_DONE || ma.pulse));
    chk("a_tick",    int'(a_tick),    int'(ma.tick));
    chk("b_count",   int'(b_count),   int2bcd(mb.cnt));
    chk("b_running", int'(b_running), int'(mb.mode == M_RUN));
    chk("b_done",    int'(b_done),    int'(mb.mode == M_DONE || mb.pulse));
    chk("b_tick",    int'(b_tick),    int'(mb.tick));
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_a_count", int'(a_count), 32'h0);
    chk("rst_b_done", int'(b_done), 32'h0);
    rst = 1'b1;
    @(negedge clk);

`ifndef BCD_TIMER_AUTO_RELOAD_EN
    a_load = 1'b1; a_lv = 8'h12; @(negedge clk);
    a_load = 1'b0; a_start = 1'b1; @(negedge clk);
    a_start = 1'b0;
    chk("cd_start_count", int'(a_count), 32'h12);
    chk("cd_start_run", int'(a_running), 32'h1);
    ticks = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (a_tick) ticks++;
      if (k == 1) chk("cd_k1", int'(a_count), 32'h11);
      if (k == 3) chk("cd_k3", int'(a_count), 32'h09);
      if (k == 12) begin
        chk("cd_zero", int'(a_count), 32'h00);
        chk("cd_done", int'(a_done), 32'h1);
      end
    end
    chk("cd_ticks", ticks, 12);
`else
    a_load = 1'b1; a_lv = 8'h03; @(negedge clk);
    a_load = 1'b0; a_start = 1'b1; @(negedge clk);
    a_start = 1'b0;
    @(negedge clk); chk("ar_k1", int'(a_count), 32'h02);
    @(negedge clk); chk("ar_k2", int'(a_count), 32'h01);
    @(negedge clk); chk("ar_k3", int'(a_count), 32'h03);
    chk("ar_done_pulse", int'(a_done), 32'h1);
    chk("ar_running", int'(a_running), 32'h1);
    @(negedge clk); chk("ar_k4", int'(a_count), 32'h02);
    chk("ar_done_low", int'(a_done), 32'h0);
`endif

    a_load = 1'b1; a_lv = 8'hAF; @(negedge clk);
    a_load = 1'b0;
    chk("clamp_count", int'(a_count), 32'h99);
    chk("clamp_done", int'(a_done), 32'h0);
    a_load = 1'b1; a_start = 1'b1; a_lv = 8'h25; @(negedge clk);
    a_load = 1'b0; a_start = 1'b0;
    chk("ldstart_count", int'(a_count), 32'h25);
    chk("ldstart_idle", int'(a_running), 32'h0);
    a_load = 1'b1; a_lv = 8'h00; @(negedge clk);
    a_load = 1'b0; a_start = 1'b1; @(negedge clk);
    a_start = 1'b0;
    chk("zero_start_done", int'(a_done), 32'h1);
    a_start = 1'b1; @(negedge clk);
    a_start = 1'b0;
    chk("done_sticky", int'(a_done), 32'h1);

    b_load = 1'b1; b_lv = 12'h005; @(negedge clk);
    b_load = 1'b0; b_start = 1'b1; @(negedge clk);
    b_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pz_before", int'(b_count), 32'h004);
    b_stop = 1'b1; @(negedge clk);
    b_stop = 1'b0;
    chk("pz_held", int'(b_count), 32'h004);
    chk("pz_not_run", int'(b_running), 32'h0);
    repeat (3) @(negedge clk);
    chk("pz_still", int'(b_count), 32'h004);
    b_start = 1'b1; @(negedge clk);
    b_start = 1'b0;
    chk("rs_r0", int'(b_count), 32'h004);
    @(negedge clk); chk("rs_r1", int'(b_count), 32'h004);
    @(negedge clk); chk("rs_r2", int'(b_count), 32'h003);
    chk("rs_tick", int'(b_tick), 32'h1);

    b_load = 1'b1; b_lv = 12'h100; @(negedge clk);
    b_load = 1'b0; b_start = 1'b1; @(negedge clk);
    b_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("cascade_1", int'(b_count), 32'h099);
    repeat (4) @(negedge clk);
    chk("cascade_2", int'(b_count), 32'h098);

    b_load = 1'b1; b_lv = 12'h037; @(negedge clk);
    b_load = 1'b0; b_start = 1'b1; @(negedge clk);
    b_start = 1'b0;
    chk("mid_run", int'(b_running), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_count", int'(b_count), 32'h000);
    chk("async_running", int'(b_running), 32'h0);
    chk("async_done", int'(b_done), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      a_load  = ($urandom_range(0, 19) == 0);
      a_stop  = ($urandom_range(0, 15) == 0);
      a_start = ($urandom_range(0, 5) == 0);
      a_lv    = 8'($urandom);
      b_load  = ($urandom_range(0, 39) == 0);
      b_stop  = ($urandom_range(0, 15) == 0);
      b_start = ($urandom_range(0, 5) == 0);
      b_lv    = {4'($urandom_range(0, 1)), 8'($urandom)};
      rst     = ($urandom_range(0, 299) != 0);
    end

    @(negedge clk);
    a_load = 1'b0; a_stop = 1'b0; a_start = 1'b0;
    b_load = 1'b0; b_stop = 1'b0; b_start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
- Controller that sequences a cascade of decade (0-9) digit counters as a programmable multi-digit BCD down-timer.
- Accepts start/stop/load commands, prescales the system clock into count ticks, borrows between digits and flags terminal count.
- Sits beside the CPU datapath as the timer peripheral; the CPU writes the load value and polls `running`/`done`.

Parameters:
- DIGITS, 2, number of cascaded BCD digits; count width is 4*DIGITS.
- PRESCALE, 1, clock cycles per count tick; 1 means a tick every cycle; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- load  input  1  load `load_val` into the count and the reload register.
- load_val  input  4*DIGITS  BCD preset; any nibble >9 is clamped to 9 on load.
- count  output  4*DIGITS  current BCD count, registered.
- running  output  1  high in RUN state.
- done  output  1  high in DONE state.
- tick  output  1  one-cycle pulse on each decrement.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, state=IDLE, running=0, done=0, tick=0.
  - Prescaler=0; reload register=0.
  - All effects are immediate, including mid-RUN.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority in one cycle: load > stop > start.
- load, any state:
  - count and reload register take the clamped `load_val` at the next edge.
  - State goes to IDLE and the prescaler clears.
- start:
  - IDLE/PAUSE with count≠0 -> RUN.
  - IDLE with count=0 -> DONE next cycle.
  - DONE -> ignored.
  - RUN -> no effect.
- stop:
  - RUN -> PAUSE; the prescaler value is held, not cleared.
  - Other states: no effect.
- RUN:
  - Prescaler counts 0..PRESCALE-1.
  - When it wraps, tick=1 for that cycle and count decrements by 1 in BCD.
  - Lowest digit 0 -> 9 with a borrow into the next digit; this cascades.
  - Decrement to all-zero -> DONE in the same edge; tick is still asserted on that edge.
- First tick after start arrives PRESCALE cycles after the start edge (PRESCALE=1: first decrement on the edge after start is sampled).
- DONE:
  - count stays 0 and done=1.
  - Leaves DONE only on load or reset.
- Simultaneous start and stop in RUN: stop wins, go to PAUSE.
- The count never underflows past 0 and never holds a non-BCD nibble.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - In RUN, the decrement that would reach zero instead loads the reload register and stays in RUN.
  - done pulses high for exactly that one cycle.
  - A reload value of 0 behaves as non-reload (enters DONE).
- Undefined: behaviour exactly as above; the reload register still exists but is used only as the stored preset.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3), BCD_MAX=4'd9, and the nibble width constant.
- Sub-module bcd_digit_dn, one per digit:
  - Inputs: clk, rst, load, load_nibble, dec_en (borrow-in).
  - Outputs: 4-bit digit and borrow_out (digit==0 && dec_en).
  - Clamping of >9 nibbles is done inside it.
- The top level holds the FSM, the prescaler and the generate loop chaining borrows.

Test Plan:
- Reset: assert rst=0 mid-RUN with count=8'h37 -> count=8'h00, running=0, done=0 immediately, without waiting for a clock edge.
- Basic countdown, PRESCALE=1: load 8'h12, start -> count steps 12,11,10,09,...,01,00 on successive cycles; done=1 on the cycle count reads 00; 12 tick pulses.
- Prescale and pause, PRESCALE=4: load 8'h05, start, stop after 6 cycles -> count=8'h04 held.
  - Start again -> next decrement after 2 more cycles, confirming the prescaler is held.
- Clamp and priority:
  - load 8'hAF -> count=8'h99.
  - load+start in the same cycle -> IDLE, running=0.
  - start with count=0 -> done=1 next cycle.
- Borrow cascade, DIGITS=3: load 12'h100, start -> next value 12'h099, then 12'h098.
- With BCD_TIMER_AUTO_RELOAD_EN, PRESCALE=1: load 8'h03, start -> count sequence 03,02,01,03,02,01,...
  - done pulses for one cycle at each reload; running stays 1.
